// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter in front of a fixed-latency data memory
module dmem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        id;
    logic        we_l;
    logic        oor_l;
    logic        sel;
    logic        g_we;
    logic        g_oor;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [31:0] resp_data;

    // pick the winner: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        sel       = (req0 && req1) ? ~last_grant : req1;
        g_we      = sel ? we1 : we0;
        g_addr    = sel ? addr1 : addr0;
        g_wdata   = sel ? wdata1 : wdata0;
        g_oor     = |g_addr[31:ADDR_W];
        resp_data = (we_l || oor_l) ? 32'd0 : mem_rdata;
    end

    // IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one ack cycle) -> IDLE, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            id         <= 1'b0;
            we_l       <= 1'b0;
            oor_l      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state      <= ACCESS;
                    cnt        <= LAT;
                    id         <= sel;
                    last_grant <= sel;
                    we_l       <= g_we;
                    oor_l      <= g_oor;
                    mem_addr   <= g_addr[ADDR_W-1:0];
                    mem_wdata  <= g_wdata;
                    mem_we     <= g_we && !g_oor;
                    mem_re     <= !g_we && !g_oor;
                    busy       <= 1'b1;
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= RESP;
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (id) begin
                            ack1   <= 1'b1;
                            err1   <= oor_l;
                            rdata1 <= resp_data;
                        end else begin
                            ack0   <= 1'b1;
                            err0   <= oor_l;
                            rdata0 <= resp_data;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with per-port requester agents and a memory model
module tb_dmem_arbiter;
    localparam int AW  = 9;
    localparam int LAT = 2;
    localparam int LIM = 2 * (LAT + 2);

    typedef struct {logic w; logic [31:0] a; logic [31:0] d;} rq_t;
    typedef struct {logic [31:0] rdata; logic err;} exp_t;
    typedef struct {logic p; int c;} ack_t;

    logic clk = 0, rst_n = 0;
    logic req0, req1, we0, we1, ack0, ack1, err0, err1, mem_re, mem_we, busy;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];
    rq_t  rq0[$], rq1[$];
    exp_t exp0[$], exp1[$];
    ack_t ack_log[$];
    int cyc = 0, st0 = 0, st1 = 0, we_cnt = 0, acks0 = 0, acks1 = 0;
    int checks = 0, errors = 0;

    dmem_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected response computed from the reference memory at issue time
    task automatic mk(input logic w, input logic [31:0] a, input logic [31:0] d, output exp_t e);
        logic [AW-1:0] ix;
        ix      = a[AW-1:0];
        e.err   = |a[31:AW];
        e.rdata = (w || e.err) ? 32'd0 : ref_mem[ix];
        if (w && !e.err) ref_mem[ix] = d;
    endtask

    // port 0 requester: holds req until ack, drops it on the edge ending the ack cycle
    initial begin
        rq_t r;
        exp_t e;
        logic seen;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        forever begin
            @(negedge clk) seen = ack0;
            @(posedge clk) #1;
            if (!rst_n) req0 = 0;
            else begin
                if (req0 && seen) req0 = 0;
                if (!req0 && rq0.size() != 0) begin
                    r = rq0.pop_front();
                    mk(r.w, r.a, r.d, e);
                    exp0.push_back(e);
                    we0 = r.w; addr0 = r.a; wdata0 = r.d; req0 = 1; st0 = cyc;
                end
            end
        end
    end

    // port 1 requester
    initial begin
        rq_t r;
        exp_t e;
        logic seen;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        forever begin
            @(negedge clk) seen = ack1;
            @(posedge clk) #1;
            if (!rst_n) req1 = 0;
            else begin
                if (req1 && seen) req1 = 0;
                if (!req1 && rq1.size() != 0) begin
                    r = rq1.pop_front();
                    mk(r.w, r.a, r.d, e);
                    exp1.push_back(e);
                    we1 = r.w; addr1 = r.a; wdata1 = r.d; req1 = 1; st1 = cyc;
                end
            end
        end
    end

    // response monitor: pops the scoreboard on every ack
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_we) we_cnt++;
            if (mem_re || mem_we) chk("strobe_excl", {31'd0, mem_re && mem_we}, 0);
            if (ack0 || ack1) chk("ack_excl", {31'd0, ack0 && ack1}, 0);
            if (ack0) begin
                acks0++;
                ack_log.push_back('{1'b0, cyc});
                if (exp0.size() == 0) chk("unexpected_ack0", 1, 0);
                else begin
                    e = exp0.pop_front();
                    chk("rdata0", rdata0, e.rdata);
                    chk("err0", {31'd0, err0}, {31'd0, e.err});
                    chk("wait0", {31'd0, (cyc - st0) <= LIM}, 1);
                end
            end
            if (ack1) begin
                acks1++;
                ack_log.push_back('{1'b1, cyc});
                if (exp1.size() == 0) chk("unexpected_ack1", 1, 0);
                else begin
                    e = exp1.pop_front();
                    chk("rdata1", rdata1, e.rdata);
                    chk("err1", {31'd0, err1}, {31'd0, e.err});
                    chk("wait1", {31'd0, (cyc - st1) <= LIM}, 1);
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || exp0.size() != 0 || exp1.size() != 0
                || req0 || req1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, n < budget}, 1);
    endtask

    initial begin
        int c0, w0, n0, n1;
        logic [31:0] keep, r1;
        for (int i = 0; i < 512; i++) begin
            mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_re_we", {30'd0, mem_re, mem_we}, 0);
        chk("rst_ack", {30'd0, ack0, ack1}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_mem_addr", {23'd0, mem_addr}, 0);
        rst_n = 1;

        // simultaneous requests: port 0 first, then alternation
        @(negedge clk);
        ack_log.delete();
        rq0.push_back('{1'b0, 32'd10, 32'd0});
        rq0.push_back('{1'b0, 32'd11, 32'd0});
        rq1.push_back('{1'b0, 32'd20, 32'd0});
        @(posedge clk);
        @(negedge clk) c0 = cyc;
        wait_done(100);
        chk("tie_n", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            chk("tie_p_a", {31'd0, ack_log[0].p}, 0);
            chk("tie_c_a", ack_log[0].c, c0 + 3);
            chk("tie_p_b", {31'd0, ack_log[1].p}, 1);
            chk("tie_c_b", ack_log[1].c, c0 + 7);
            chk("tie_p_c", {31'd0, ack_log[2].p}, 0);
            chk("tie_c_c", ack_log[2].c, c0 + 11);
        end

        // single load, cycle by cycle
        r1 = rdata1;
        rq0.push_back('{1'b0, 32'd5, 32'd0});
        @(posedge clk);
        @(negedge clk);
        chk("ld_c0_busy", {31'd0, busy}, 0);
        chk("ld_c0_re", {31'd0, mem_re}, 0);
        @(negedge clk);
        chk("ld_c1_re", {31'd0, mem_re}, 1);
        chk("ld_c1_busy", {31'd0, busy}, 1);
        chk("ld_c1_addr", {23'd0, mem_addr}, 5);
        @(negedge clk);
        chk("ld_c2_re", {31'd0, mem_re}, 1);
        @(negedge clk);
        chk("ld_c3_ack", {31'd0, ack0}, 1);
        chk("ld_c3_busy", {31'd0, busy}, 1);
        chk("ld_c3_re", {31'd0, mem_re}, 0);
        chk("ld_c3_rdata", rdata0, 32'hDEADBEEF);
        chk("ld_c3_other", rdata1, r1);
        @(negedge clk);
        chk("ld_c4_busy", {31'd0, busy}, 0);
        chk("ld_c4_ack", {31'd0, ack0}, 0);
        chk("ld_c4_hold", rdata0, 32'hDEADBEEF);
        wait_done(50);

        // port 1 store at top word, then read back from port 0
        w0 = we_cnt;
        rq1.push_back('{1'b1, 32'h1FF, 32'h12345678});
        wait_done(50);
        chk("st_we_cycles", we_cnt - w0, 2);
        chk("st_mem", mem[9'h1FF], 32'h12345678);
        chk("st_rdata1", rdata1, 0);
        rq0.push_back('{1'b0, 32'h1FF, 32'd0});
        wait_done(50);
        chk("st_readback", rdata0, 32'h12345678);

        // out-of-range store
        w0 = we_cnt;
        keep = mem[0];
        rq0.push_back('{1'b1, 32'h200, 32'hCAFEF00D});
        @(posedge clk);
        repeat (4) @(negedge clk);
        chk("oor_ack", {31'd0, ack0}, 1);
        chk("oor_err", {31'd0, err0}, 1);
        wait_done(50);
        chk("oor_no_we", we_cnt - w0, 0);
        chk("oor_mem", mem[0], keep);

        // reset in the middle of an access
        n0 = acks0;
        rq0.push_back('{1'b0, 32'd7, 32'd0});
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("mid_re_before", {31'd0, mem_re}, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_re", {31'd0, mem_re}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        exp0.delete();
        repeat (2) @(negedge clk);
        chk("mid_no_ack", {31'd0, ack0}, 0);
        chk("mid_no_ack_cnt", acks0, n0);
        #2 rst_n = 1;
        ack_log.delete();
        rq0.push_back('{1'b0, 32'd7, 32'd0});
        rq1.push_back('{1'b0, 32'd8, 32'd0});
        wait_done(100);
        chk("post_rst_n", ack_log.size(), 2);
        if (ack_log.size() != 0) chk("post_rst_first", {31'd0, ack_log[0].p}, 0);

        // random back-to-back traffic, disjoint address halves per port
        n0 = acks0;
        n1 = acks1;
        for (int i = 0; i < 24; i++) begin
            rq0.push_back('{1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 32'h400 : {23'd0, 8'($urandom), 1'b0}, $urandom});
            rq1.push_back('{1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 32'h10000 : {23'd0, 8'($urandom), 1'b1}, $urandom});
        end
        wait_done(3000);
        chk("rand_acks0", acks0 - n0, 24);
        chk("rand_acks1", acks1 - n1, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
